// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the control unit and the HI/LO multiply/divide unit.
// The slave side is the execution unit; the master side is the pipeline driving it.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave (
    input  start, op_div, is_signed, a, b, wr_hi, wr_lo, wr_data,
    output busy, done, div_zero, hi, lo
  );

  modport master (
    output start, op_div, is_signed, a, b, wr_hi, wr_lo, wr_data,
    input  busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with architectural HI/LO registers.
// Works on operand magnitudes and applies sign correction in a single FIX cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  hilo_muldiv_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               op_div_q, op_div_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_ext;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] acc_neg;

  assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

  // Multiply step: the carry out of the upper-half add becomes the new MSB after the shift.
  assign mul_sum = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                            : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

  // Divide step: the remainder is widened by one bit so the bit shifted out is not lost.
  assign rem_ext = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_ge  = (rem_ext >= {1'b0, mcand_q});
  assign rem_sub = rem_ext[WIDTH-1:0] - mcand_q;
  assign rem_new = rem_ge ? rem_sub : rem_ext[WIDTH-1:0];

  assign acc_neg = ~acc_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    op_div_d   = op_div_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          neg_quo_d  = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d  = bus.is_signed & bus.a[WIDTH-1];
          op_div_d   = bus.op_div;
          div_zero_d = 1'b0;
          cnt_d      = CW'(WIDTH - 1);
          if (bus.op_div && (bus.b == '0)) begin
            // Raw dividend and all-ones quotient are parked for FIX to copy out.
            dz_d    = 1'b1;
            acc_d   = {bus.a, {WIDTH{1'b1}}};
            mcand_d = '0;
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            acc_d   = bus.op_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            mcand_d = bus.op_div ? b_mag : a_mag;
            state_d = RUN;
          end
        end else begin
          if (bus.wr_hi) hi_d = bus.wr_data;
          if (bus.wr_lo) lo_d = bus.wr_data;
        end
      end

      RUN: begin
        if (op_div_q) begin
          acc_d = {rem_new, acc_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end

      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          hi_d       = acc_q[2*WIDTH-1:WIDTH];
          lo_d       = acc_q[WIDTH-1:0];
          div_zero_d = 1'b1;
        end else if (op_div_q) begin
          lo_d = neg_quo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_quo_q ? acc_neg : acc_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      op_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      op_div_q   <= op_div_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit: latency, busy length, results, flags,
// interference while busy, direct writes and mid-operation reset.
module tb_hilo_muldiv_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(WIDTH)) bus ();

  hilo_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain op; mode 1: inject start at cycle 5 and wr_hi at cycle 10;
  // mode 2: assert reset at cycle 12 and stop.
  task automatic do_op(input string tag, input logic d, input logic s,
                       input logic [31:0] av, input logic [31:0] bv,
                       input int mode, input int exp_lat,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic exp_dz);
    int lat;
    int busy_cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.op_div = d; bus.is_signed = s; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 32'h0BAD_0BAD; bus.b = 32'h0000_0003; bus.op_div = ~d; bus.is_signed = ~s;
    busy_cyc = bus.busy ? 1 : 0;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_cyc++;
      if (mode == 1 && lat == 5) begin
        bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd7;
      end
      if (mode == 1 && lat == 6) bus.start = 1'b0;
      if (mode == 1 && lat == 10) begin
        bus.wr_hi = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
      end
      if (mode == 1 && lat == 11) bus.wr_hi = 1'b0;
      if (mode == 2 && lat == 12) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check({tag, " rst busy"}, 64'(bus.busy), 64'd0);
        check({tag, " rst done"}, 64'(bus.done), 64'd0);
        check({tag, " rst hi"}, 64'(bus.hi), 64'd0);
        check({tag, " rst lo"}, 64'(bus.lo), 64'd0);
        $display("op %s: reset after %0d edges", tag, lat);
        return;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy cycles"}, 64'(busy_cyc), 64'(exp_lat));
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    check({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(bus.done), 64'd0);
    $display("op %s: a=%h b=%h lat=%0d hi=%h lo=%h dz=%0b", tag, av, bv, lat, bus.hi, bus.lo, bus.div_zero);
  endtask

  initial begin
    bus.start = 1'b0; bus.op_div = 1'b0; bus.is_signed = 1'b0;
    bus.a = '0; bus.b = '0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    $display("reset: busy=%0b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

    do_op("multu ffffffff*2", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 0, 33,
          32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    do_op("mult -3*5", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 0, 33,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    do_op("mult min*min", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 0, 33,
          32'h4000_0000, 32'h0000_0000, 1'b0);
    do_op("div -7/2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, 33,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op("divu fffffff9/2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 0, 33,
          32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    do_op("div overflow", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33,
          32'h0000_0000, 32'h8000_0000, 1'b0);
    do_op("div by zero", 1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, 0, 1,
          32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    do_op("divu 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 0, 33,
          32'd2, 32'd14, 1'b0);
    do_op("multu interfered", 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0001, 1, 33,
          32'h0000_0001, 32'h0001_0000, 1'b0);

    @(negedge clk);
    bus.wr_lo = 1'b1; bus.wr_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.wr_lo = 1'b0;
    check("mtlo lo", 64'(bus.lo), 64'hCAFE_F00D);
    check("mtlo hi kept", 64'(bus.hi), 64'h0000_0001);
    $display("mtlo: hi=%h lo=%h", bus.hi, bus.lo);

    do_op("divu reset", 1'b1, 1'b0, 32'd100, 32'd7, 2, 33, 32'd0, 32'd0, 1'b0);
    do_op("divu after reset", 1'b1, 1'b0, 32'd100, 32'd7, 0, 33,
          32'd2, 32'd14, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide execution unit with architectural HI/LO registers.
- Sits downstream of the control unit. It executes the MULT and DIV opcodes the control unit decodes, and supplies HI/LO values for MFHI/MFLO.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle. Raises busy so the pipeline stalls until results are written.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only when busy=0
op_div  input  1  0 = multiply, 1 = divide
is_signed  input  1  1 = two's-complement operands (MULT/DIV), 0 = unsigned (MULTU/DIVU)
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
wr_hi  input  1  direct write of HI from wr_data (MTHI)
wr_lo  input  1  direct write of LO from wr_data (MTLO)
wr_data  input  WIDTH  data for direct HI/LO writes
busy  output  1  operation in progress; pipeline must stall MFHI/MFLO/MULT/DIV
done  output  1  one-cycle pulse: HI/LO just updated by a completed operation
div_zero  output  1  sticky flag: last completed divide had b==0; cleared by next accepted start
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset: state=IDLE; busy, done, div_zero, hi and lo all 0; internal accumulators cleared. Reset mid-operation aborts it immediately; no partial result reaches hi/lo.
- States:
  - IDLE: waits for start.
  - RUN: WIDTH iterations.
  - FIX: sign correction and HI/LO write.
  - No separate DONE state; done is registered from FIX.
- IDLE, start=1 at edge E0:
  - Latch magnitudes |a|, |b| (absolute value only when is_signed=1).
  - Latch neg_q = sign(a) XOR sign(b) and neg_r = sign(a).
  - Clear div_zero, load iteration counter = WIDTH-1, busy=1.
  - Go to RUN, or go to FIX directly if op_div=1 and b==0.
- RUN, multiply: each cycle, if multiplier LSB = 1, add the multiplicand to the upper half of the 2*WIDTH product. Then shift right by 1; the carry of the add enters the MSB.
- RUN, divide: each cycle, shift the {remainder, quotient} pair left by 1. Trial-subtract the divisor from the remainder. If the result is non-negative, keep it and set quotient bit 0.
- The counter decrements each RUN cycle; the last RUN cycle (counter==0) transitions to FIX. RUN lasts exactly WIDTH cycles (E1..E_WIDTH).
- FIX (edge E_WIDTH+1):
  - Multiply: {hi,lo} = neg_q ? -product : product.
  - Divide: lo = neg_q ? -quotient : quotient; hi = neg_r ? -remainder : remainder.
  - done=1 and busy=0 for the cycle following this edge; state goes to IDLE.
- Latency: done visible WIDTH+1 edges after the start edge (33 for WIDTH=32). busy is high for exactly WIDTH+1 cycles.
- Divide by zero: FIX at E1 (latency 1 edge), no iteration.
  - hi = a (unmodified input value), lo = all ones, div_zero = 1, done pulses.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, falling naturally out of the magnitude algorithm; no special case.
- start while busy=1: ignored, no queueing.
- start in the same cycle as done: accepted, since busy is already 0.
- Direct writes: wr_hi/wr_lo take effect at the edge only when busy=0 and start=0.
  - With start=1 in the same cycle, start wins and the writes are dropped.
  - Writes while busy are dropped.
  - Simultaneous wr_hi and wr_lo write the same wr_data to both.
- hi/lo hold their values between completions and are never altered by a dropped or aborted operation.
- Operand inputs a, b, op_div and is_signed are only sampled at the start edge; later changes have no effect.

Test Plan:
- Unsigned multiply a=0xFFFFFFFF, b=0x00000002 -> after 33 edges hi=0x00000001, lo=0xFFFFFFFE, done high exactly one cycle, busy high for 33 cycles.
- Signed multiply a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Signed multiply a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- Signed divide a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned divide same operands -> lo=0x7FFFFFFC, hi=0x00000001. Overflow case 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0.
- Divide by zero a=0x12345678, b=0 -> done one edge after start, hi=0x12345678, lo=0xFFFFFFFF, div_zero=1. Next accepted start clears div_zero.
- During a multiply: assert start with new operands at cycle 5 and wr_hi at cycle 10 -> both ignored, result matches the first operation. Assert wr_lo with wr_data=0xCAFEF00D while idle -> lo=0xCAFEF00D next cycle, hi unchanged.
- Reset asserted at cycle 12 of a divide -> next cycle busy=0, done=0, hi=lo=0. A new start then completes normally in 33 edges.
